// File: rtl/dmem_pkg.sv
// Shared types and helpers for the parametrised data memory controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      WAIT
   } state_t;

   localparam int unsigned LAT_W = 4;

   function automatic int unsigned depth(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic                re_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);

   localparam int unsigned DEPTH = depth(ADDR_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the storage array has no reset; zeroing it is the job of the INIT walk.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request port, programmable response latency
// and an optional zero-fill of the array after reset.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 11,
   parameter int unsigned LATENCY        = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                busy
);

   localparam logic [LAT_W-1:0]  LAT_LOAD    = LAT_W'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(depth(ADDR_W) - 1);
   localparam state_t            RESET_STATE = CLEAR_ON_RESET ? INIT : IDLE;

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [ADDR_W-1:0]   clr_q, clr_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_is_wr_q, rsp_is_wr_d;
   logic                accept;
   logic                clearing;
   logic                arr_we;
   logic                arr_re;
   logic [DATA_W/8-1:0] arr_be;
   logic [ADDR_W-1:0]   arr_addr;
   logic [DATA_W-1:0]   arr_wdata;
   logic [DATA_W-1:0]   arr_rdata;

   assign clearing  = (state_q == INIT);
   assign busy      = clearing;
   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid & req_ready;

   // The single array port is owned by the clear walk while INIT is active.
   assign arr_we    = clearing | (accept & req_we);
   assign arr_re    = accept & ~req_we;
   assign arr_be    = clearing ? '1 : req_be;
   assign arr_addr  = clearing ? clr_q : req_addr;
   assign arr_wdata = clearing ? '0 : req_wdata;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      clr_d       = clr_q;
      rsp_valid_d = 1'b0;
      rsp_is_wr_d = rsp_is_wr_q;
      case (state_q)
         INIT: begin
            clr_d = clr_q + ADDR_W'(1);
            if (clr_q == LAST_ADDR) state_d = IDLE;
         end
         IDLE: begin
            if (accept) begin
               rsp_is_wr_d = req_we;
               if (LATENCY == 1) begin
                  rsp_valid_d = 1'b1;
               end else begin
                  lat_d   = LAT_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            lat_d = lat_q - LAT_W'(1);
            if (lat_q == LAT_W'(1)) begin
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RESET_STATE;
         lat_q       <= '0;
         clr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_is_wr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         clr_q       <= clr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_is_wr_q <= rsp_is_wr_d;
      end
   end

   dmem_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_array (
      .clk    (clk),
      .rst_n  (reset),
      .we_i   (arr_we),
      .be_i   (arr_be),
      .re_i   (arr_re),
      .addr_i (arr_addr),
      .wdata_i(arr_wdata),
      .rdata_o(arr_rdata)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_is_wr_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three configurations checked every cycle against a
// transaction-level model, plus hand-computed scenario expectations.
module tb_data_memory_ctrl;

   localparam int NDUT  = 3;
   localparam int AW    = 11;
   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst_n     [NDUT];
   logic        req_valid [NDUT];
   logic        req_ready [NDUT];
   logic        req_we    [NDUT];
   logic [AW-1:0] req_addr [NDUT];
   logic [31:0] req_wdata [NDUT];
   logic [3:0]  req_be    [NDUT];
   logic        rsp_valid [NDUT];
   logic [31:0] rsp_rdata [NDUT];
   logic        busy      [NDUT];

   always #5 clk = ~clk;

   // Instance 0: LATENCY=2 with clear; 1: LATENCY=1 with clear; 2: LATENCY=3, no clear.
   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      data_memory_ctrl #(
         .DATA_W        (32),
         .ADDR_W        (AW),
         .LATENCY       (g == 0 ? 2 : (g == 1 ? 1 : 3)),
         .CLEAR_ON_RESET(g != 2)
      ) u_dut (
         .clk      (clk),
         .reset    (rst_n[g]),
         .req_valid(req_valid[g]),
         .req_ready(req_ready[g]),
         .req_we   (req_we[g]),
         .req_addr (req_addr[g]),
         .req_wdata(req_wdata[g]),
         .req_be   (req_be[g]),
         .rsp_valid(rsp_valid[g]),
         .rsp_rdata(rsp_rdata[g]),
         .busy     (busy[g])
      );
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
   endfunction

   function automatic bit clr_of(input int g);
      return g != 2;
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] mem_m     [NDUT][DEPTH];
   bit          pend_v    [NDUT];
   int          pend_rem  [NDUT];
   logic [31:0] pend_data [NDUT];
   int          clr_left  [NDUT];
   int          acc_cnt   [NDUT];

   function automatic bit m_ready(input int g);
      return (rst_n[g] === 1'b1) && (clr_left[g] == 0) && (!pend_v[g] || pend_rem[g] == 0);
   endfunction

   function automatic bit m_valid(input int g);
      return pend_v[g] && (pend_rem[g] == 0);
   endfunction

   initial begin
      for (int g = 0; g < NDUT; g++) begin
         pend_v[g]   = 1'b0;
         pend_rem[g] = 0;
         clr_left[g] = 0;
         acc_cnt[g]  = 0;
         for (int a = 0; a < DEPTH; a++) mem_m[g][a] = '0;
      end
      forever begin
         @(posedge clk);
         for (int g = 0; g < NDUT; g++) begin
            bit acc;
            if (rst_n[g] !== 1'b1) begin
               pend_v[g]   = 1'b0;
               clr_left[g] = clr_of(g) ? DEPTH : 0;
               if (clr_of(g)) for (int a = 0; a < DEPTH; a++) mem_m[g][a] = '0;
            end else begin
               acc = (req_valid[g] === 1'b1) && m_ready(g);
               if (pend_v[g]) begin
                  if (pend_rem[g] == 0) pend_v[g] = 1'b0;
                  else pend_rem[g]--;
               end
               if (clr_left[g] > 0) clr_left[g]--;
               if (acc) begin
                  acc_cnt[g]++;
                  if (req_we[g]) begin
                     for (int b = 0; b < 4; b++)
                        if (req_be[g][b]) mem_m[g][req_addr[g]][8*b +: 8] = req_wdata[g][8*b +: 8];
                     pend_data[g] = '0;
                  end else begin
                     pend_data[g] = mem_m[g][req_addr[g]];
                  end
                  pend_v[g]   = 1'b1;
                  pend_rem[g] = lat_of(g) - 1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int          rsp_cnt [NDUT];
   logic [31:0] log1 [$];

   initial begin
      for (int g = 0; g < NDUT; g++) rsp_cnt[g] = 0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < NDUT; g++) begin
            if (rst_n[g] === 1'b1) begin
               check($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(clr_left[g] > 0));
               check($sformatf("req_ready[%0d]", g), 32'(req_ready[g]), 32'(m_ready(g)));
               check($sformatf("rsp_valid[%0d]", g), 32'(rsp_valid[g]), 32'(m_valid(g)));
               if (m_valid(g)) check($sformatf("rsp_rdata[%0d]", g), rsp_rdata[g], pend_data[g]);
               if (rsp_valid[g] === 1'b1) begin
                  rsp_cnt[g]++;
                  if (g == 1) log1.push_back(rsp_rdata[1]);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int last_wait;

   task automatic send(input int g, input bit we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
      int k;
      req_valid[g] = 1'b1;
      req_we[g]    = we;
      req_addr[g]  = a;
      req_wdata[g] = d;
      req_be[g]    = be;
      k = 0;
      while (!m_ready(g) && k < 64) begin
         @(negedge clk);
         k++;
      end
      last_wait = k;
      checks++;
      if (k >= 64) begin
         errors++;
         $display("FAIL accept_timeout[%0d]: waited %0d cycles, want < 64", g, k);
      end
      @(negedge clk);
      req_valid[g] = 1'b0;
   endtask

   task automatic wait_rsp(input int g, output int lat, output logic [31:0] data);
      int k;
      k = 0;
      while (rsp_valid[g] !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 40) begin
         errors++;
         $display("FAIL rsp_timeout[%0d]: waited %0d cycles, want < 40", g, k);
      end
      lat  = k + 1;
      data = rsp_rdata[g];
   endtask

   task automatic rand_run(input int g, input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(g, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)));
      end
   endtask

   task automatic count_busy(input int g, output int n);
      n = 0;
      while (busy[g] === 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          lat, n, c0, idx0;
      logic [31:0] d;
      logic [31:0] pat [4];
      pat[0] = 32'h01234567;
      pat[1] = 32'h89ABCDEF;
      pat[2] = 32'hFFFF0000;
      pat[3] = 32'h0000FFFF;

      for (int g = 0; g < NDUT; g++) begin
         rst_n[g]     = 1'b0;
         req_valid[g] = 1'b0;
         req_we[g]    = 1'b0;
         req_addr[g]  = '0;
         req_wdata[g] = '0;
         req_be[g]    = '0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < NDUT; g++) rst_n[g] = 1'b1;

      // Reset clear: 2048 busy cycles; the no-clear instance is ready at once.
      check("nc_busy_after_release", 32'(busy[2]), 32'd0);
      check("nc_ready_after_release", 32'(req_ready[2]), 32'd1);
      count_busy(0, n);
      check("clear_cycles", 32'(n), 32'd2048);
      send(0, 1'b0, 11'h7FF, 32'h0, 4'h0);
      wait_rsp(0, lat, d);
      check("read_7ff_after_clear", d, 32'h0000_0000);

      // Write/read with LATENCY=2.
      send(0, 1'b1, 11'h123, 32'hDEADBEEF, 4'hF);
      wait_rsp(0, lat, d);
      check("write_latency", 32'(lat), 32'd2);
      check("write_rsp_zero", d, 32'h0);
      send(0, 1'b0, 11'h123, 32'h0, 4'h0);
      wait_rsp(0, lat, d);
      check("read_latency", 32'(lat), 32'd2);
      check("read_deadbeef", d, 32'hDEADBEEF);

      // Byte enables.
      send(0, 1'b1, 11'h123, 32'h11223344, 4'h5);
      wait_rsp(0, lat, d);
      send(0, 1'b0, 11'h123, 32'h0, 4'h0);
      wait_rsp(0, lat, d);
      check("byte_enable_merge", d, 32'hDE22BE44);

      // Stall: second request held while the first is in WAIT.
      repeat (2) @(negedge clk);
      c0 = rsp_cnt[0];
      n  = acc_cnt[0];
      send(0, 1'b0, 11'h123, 32'h0, 4'h0);
      send(0, 1'b0, 11'h124, 32'h0, 4'h0);
      check("stall_held_request_waited", 32'(last_wait), 32'd1);
      repeat (6) @(negedge clk);
      check("stall_rsp_count", 32'(rsp_cnt[0] - c0), 32'd2);
      check("stall_accept_count", 32'(acc_cnt[0] - n), 32'd2);

      rand_run(0, 200);

      // Mid-WAIT reset one cycle after a read accept, then a reset mid-INIT.
      repeat (4) @(negedge clk);
      send(0, 1'b0, 11'h123, 32'h0, 4'h0);
      c0 = rsp_cnt[0];
      rst_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      check("midreset_busy", 32'(busy[0]), 32'd1);
      repeat (100) @(negedge clk);
      check("midreset_no_rsp", 32'(rsp_cnt[0] - c0), 32'd0);
      rst_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      count_busy(0, n);
      check("init_restart_cycles", 32'(n), 32'd2048);
      send(0, 1'b0, 11'h123, 32'h0, 4'h0);
      wait_rsp(0, lat, d);
      check("read_after_reclear", d, 32'h0);

      // Back-to-back with LATENCY=1.
      idx0 = log1.size();
      n = 0;
      for (int i = 0; i < 4; i++) begin
         send(1, 1'b1, AW'(i), pat[i], 4'hF);
         n += last_wait;
         send(1, 1'b0, AW'(i), 32'h0, 4'h0);
         n += last_wait;
      end
      repeat (3) @(negedge clk);
      check("b2b_total_stall", 32'(n), 32'd0);
      check("b2b_rsp_count", 32'(log1.size() - idx0), 32'd8);
      if (log1.size() >= idx0 + 8) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_wr_rsp%0d", i), log1[idx0 + 2*i], 32'h0);
            check($sformatf("b2b_rd_rsp%0d", i), log1[idx0 + 2*i + 1], pat[i]);
         end
      end
      rand_run(1, 200);

      // No-clear instance: data survives a mid-WAIT reset.
      for (int a = 0; a < 16; a++) send(2, 1'b1, AW'(a), $urandom, 4'hF);
      send(2, 1'b1, 11'h005, 32'hCAFEF00D, 4'hF);
      wait_rsp(2, lat, d);
      check("nc_write_latency", 32'(lat), 32'd3);
      send(2, 1'b0, 11'h005, 32'h0, 4'h0);
      c0 = rsp_cnt[2];
      rst_n[2] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[2] = 1'b1;
      check("nc_busy_after_midreset", 32'(busy[2]), 32'd0);
      repeat (5) @(negedge clk);
      check("nc_midreset_no_rsp", 32'(rsp_cnt[2] - c0), 32'd0);
      send(2, 1'b0, 11'h005, 32'h0, 4'h0);
      wait_rsp(2, lat, d);
      check("nc_data_preserved", d, 32'hCAFEF00D);
      rand_run(2, 200);

      repeat (10) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
